// File: rtl/rf_write_arbiter.sv
// Two-requester arbiter for the register file write port, with one holding register per requester.
// Tie policy: fixed priority to A by default; define RF_ARB_RR_EN for round-robin.
module rf_write_arbiter #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [4:0]   a_rd,
  input  logic [n-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [4:0]   b_rd,
  input  logic [n-1:0] b_data,
  output logic         b_ready,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [n-1:0] rf_wdata,
  output logic         idle
);

  localparam int unsigned RD_W = 5;

  logic            a_full;
  logic [RD_W-1:0] a_hold_rd;
  logic [n-1:0]    a_hold_data;
  logic            b_full;
  logic [RD_W-1:0] b_hold_rd;
  logic [n-1:0]    b_hold_data;

  logic grant_a;
  logic grant_b;
  logic accept_a;
  logic accept_b;

`ifdef RF_ARB_RR_EN
  logic last_grant;

  // On a tie the requester that did not win the previous tie goes first.
  always_comb begin
    grant_a = a_full && (!b_full || last_grant);
    grant_b = b_full && (!a_full || !last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (a_full && b_full) begin
      last_grant <= grant_b;
    end
  end
`else
  always_comb begin
    grant_a = a_full;
    grant_b = b_full && !a_full;
  end
`endif

  // A slot can take a new request when empty or when it drains this edge.
  always_comb begin
    a_ready  = !rst && (!a_full || grant_a);
    b_ready  = !rst && (!b_full || grant_b);
    accept_a = a_valid && a_ready;
    accept_b = b_valid && b_ready;
  end

  assign idle = !a_full && !b_full && !rf_we;

  // Holding registers; x0 writes are acknowledged but never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full      <= 1'b0;
      a_hold_rd   <= RD_W'(0);
      a_hold_data <= n'(0);
      b_full      <= 1'b0;
      b_hold_rd   <= RD_W'(0);
      b_hold_data <= n'(0);
    end else begin
      if (accept_a && (a_rd != RD_W'(0))) begin
        a_full      <= 1'b1;
        a_hold_rd   <= a_rd;
        a_hold_data <= a_data;
      end else if (grant_a) begin
        a_full <= 1'b0;
      end
      if (accept_b && (b_rd != RD_W'(0))) begin
        b_full      <= 1'b1;
        b_hold_rd   <= b_rd;
        b_hold_data <= b_data;
      end else if (grant_b) begin
        b_full <= 1'b0;
      end
    end
  end

  // Write port registers; address/data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= RD_W'(0);
      rf_wdata <= n'(0);
    end else begin
      rf_we <= grant_a || grant_b;
      if (grant_a) begin
        rf_waddr <= a_hold_rd;
        rf_wdata <= a_hold_data;
      end else if (grant_b) begin
        rf_waddr <= b_hold_rd;
        rf_wdata <= b_hold_data;
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: A (ALU/immediate path) and B (load/multi-cycle path). Each requester has a one-entry holding register with a valid/ready handshake. The arbiter drives registered write-enable, write-address and write-data signals straight into the register file's write port. Writes to x0 are accepted and discarded, so no write cycle is spent on them.

## Interface
- n, 32, data width; must match register file width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  requester A has a write
- a_rd  in  5  A destination register
- a_data  in  n  A write data
- a_ready  out  1  A handshake accepted this cycle when a_valid && a_ready
- b_valid  in  1  requester B has a write
- b_rd  in  5  B destination register
- b_data  in  n  B write data
- b_ready  out  1  B handshake accepted this cycle when b_valid && b_ready
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  n  register file write data (registered)
- idle  out  1  both holding registers empty and rf_we low

## Operation
- State:
  - hold_a: full flag, rd, data
  - hold_b: full flag, rd, data
  - last_grant: 0 = A, 1 = B
  - output registers rf_we, rf_waddr, rf_wdata
- Grant (combinational from hold state):
  - Candidates are the full holding registers.
  - With one candidate, it wins.
  - With two candidates, the winner follows the arbitration policy (see Configuration).
  - With none, there is no grant.
- Output registers at each edge:
  - On a grant: rf_we<=1, rf_waddr/rf_wdata <= winner's rd/data, winner's full flag cleared.
  - Otherwise: rf_we<=0; rf_waddr and rf_wdata hold their values.
- Readiness:
  - a_ready = !rst && (!hold_a.full || grant_a).
  - b_ready is defined the same way for B.
  - A holding register that drains and refills on the same edge ends up full with the new request.
- Accepting a request:
  - If rd != 0, it loads the holding register.
  - If rd == 0, it is accepted and dropped: the holding register is not loaded and no rf_we is ever produced.
- Ordering:
  - Writes from the same requester issue in acceptance order.
  - There is no ordering guarantee between A and B. Issue order follows arbitration, so same-rd conflicts across requesters are the producer's responsibility.
- Reset:
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, idle=1, a_ready=b_ready=0.
  - Internal state: both full flags 0, last_grant=1.
  - Reset asserted mid-operation discards held writes. A handshake in the reset cycle is not accepted.

## Timing
- Uncontested latency: accepted at edge E0, rf_we high in the cycle after E1, register file written at E2.
- Throughput: one write per cycle in total across both requesters. An uncontested requester sustains one accept per cycle.
- Contention: the loser stays full, and its ready is low until it is granted. It is granted at the next edge if the winner does not refill. Under the round-robin policy it is granted within 2 edges in any case.
- idle reflects registered state and goes high the cycle after the last rf_we pulse.
- last_grant updates only on edges where both holding registers were full.

## Configuration
- RF_ARB_RR_EN defined: round-robin.
  - On a tie, the winner is the requester not equal to last_grant.
  - last_grant updates to the winner on each tie.
  - Because it resets to 1, A wins the first tie.
- RF_ARB_RR_EN undefined: fixed priority, A always wins ties.
  - last_grant register is removed.
  - B can starve while A streams.

## Test plan
- Reset, then A sends (rd=5, data=0xDEADBEEF) once -> a_ready=1, rf_we=1/rf_waddr=5/rf_wdata=0xDEADBEEF exactly one cycle, 2 edges after accept; idle returns to 1.
- A sends rd=0 data=0x1234 -> accepted, rf_we never asserts, idle stays 1.
- A and B valid every cycle, rd=1 and rd=2, with RF_ARB_RR_EN -> rf_waddr alternates 1,2,1,2…; each ready pattern 50%; first issued write is rd=1.
- Same stimulus without RF_ARB_RR_EN -> rf_waddr=1 every cycle, b_ready stays 0 after B's first accept, B's write issues only once A drops valid.
- A streams rd=3..7 alone, back-to-back -> a_ready constant 1, rf_waddr 3,4,5,6,7 on consecutive cycles.
- Both holding registers full, rst pulsed one cycle -> next cycle rf_we=0, idle=1, held writes never appear; ready 0 during rst.
